// File: rtl/mdu_pkg.sv
// ---------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the multiply/divide unit: operation encodings,
// controller state encodings, iteration count and small op-decode helpers.
// ---------------------------------------------------------------------------
package mdu_pkg;

    // One datapath step per bit of the 32-bit operands.
    localparam int ITERATIONS = 32;
    localparam int CNT_W      = $clog2(ITERATIONS);

    // Operation select as presented on the op port.
    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_e;

    // Signed variants work on magnitudes and fix the sign up at the end.
    function automatic logic op_is_signed(input op_e o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

    function automatic logic op_is_div(input op_e o);
        return (o == OP_DIVU) || (o == OP_DIV);
    endfunction

endpackage

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
// Iterative MIPS-style multiply/divide unit with HI/LO result registers.
// Multiplies by shift-add and divides by restoring shift-subtract, one step
// per clock, on operand magnitudes; signs are applied in a final fix-up cycle.
// Fixed latency: start accepted at edge E0, HI/LO written at edge E33.
//
// Ports
//   clk    : clock, all state changes on the rising edge
//   rst    : synchronous active-high reset, clears all state (wins over start)
//   start  : request a new operation, only honoured while busy=0
//   op     : 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a, b   : rs / rt operands, captured together with start
//   busy   : operation in progress
//   done   : one-cycle pulse following the HI/LO update
//   hi, lo : product upper/lower half, or remainder/quotient
//
// WIDTH is carried as a parameter for interface clarity; only 32 is supported.
// ---------------------------------------------------------------------------
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_e             state_reg;
    state_e             state_next;
    logic [CNT_W-1:0]   count_reg;
    op_e                op_reg;
    logic               neg_q_reg;      // product / quotient must be negated
    logic               neg_r_reg;      // remainder must be negated
    logic               div_zero_reg;   // divide with b == 0
    logic [WIDTH-1:0]   acc_hi_reg;     // partial product high / remainder
    logic [WIDTH-1:0]   acc_lo_reg;     // multiplier bits / dividend->quotient
    logic [WIDTH-1:0]   operand_reg;    // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;
    logic               done_reg;

    // -----------------------------------------------------------------------
    // Operand capture decode
    // -----------------------------------------------------------------------
    op_e                op_in;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    assign op_in = op_e'(op);

    always_comb begin
        a_neg = op_is_signed(op_in) && a[WIDTH-1];
        b_neg = op_is_signed(op_in) && b[WIDTH-1];
        // The most negative value maps onto 2^31, which is still correct
        // when read as an unsigned magnitude.
        a_mag = a_neg ? (~a + 1'b1) : a;
        b_mag = b_neg ? (~b + 1'b1) : b;
    end

    // -----------------------------------------------------------------------
    // Datapath step logic
    // -----------------------------------------------------------------------
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic               div_fits;
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quo_fixed;
    logic [WIDTH-1:0]   rem_fixed;
    logic               unused_diff_bit;

    always_comb begin
        // Multiply: add multiplicand when the current multiplier bit is set;
        // the carry-out becomes the top bit after the right shift.
        mul_sum = {1'b0, acc_hi_reg}
                + (acc_lo_reg[0] ? {1'b0, operand_reg} : {(WIDTH+1){1'b0}});

        // Divide: shift the next dividend bit into the remainder, then try
        // to subtract; a borrow out of the extra top bit means "restore".
        div_shift = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, operand_reg};
        div_fits  = ~div_diff[WIDTH+1];

        // Sign fix-up of the magnitude results.
        prod_mag   = {acc_hi_reg, acc_lo_reg};
        prod_fixed = neg_q_reg ? (~prod_mag + 1'b1) : prod_mag;
        // With b == 0 the restoring loop leaves remainder = |a|, which after
        // the remainder sign fix is exactly a; only the quotient is forced.
        quo_fixed  = div_zero_reg ? {WIDTH{1'b1}}
                   : (neg_q_reg ? (~acc_lo_reg + 1'b1) : acc_lo_reg);
        rem_fixed  = neg_r_reg ? (~acc_hi_reg + 1'b1) : acc_hi_reg;
    end

    // Accepted remainders are below the divisor, so bit WIDTH of the
    // difference is always zero when it is used.
    assign unused_diff_bit = div_diff[WIDTH];

    // -----------------------------------------------------------------------
    // Controller: next state and busy
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        busy       = 1'b1;
        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                if (count_reg == CNT_W'(ITERATIONS - 1)) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                busy       = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg    <= '0;
            op_reg       <= OP_MULTU;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            div_zero_reg <= 1'b0;
            acc_hi_reg   <= '0;
            acc_lo_reg   <= '0;
            operand_reg  <= '0;
            hi_reg       <= '0;
            lo_reg       <= '0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        count_reg    <= '0;
                        op_reg       <= op_in;
                        neg_q_reg    <= a_neg ^ b_neg;
                        neg_r_reg    <= a_neg;
                        div_zero_reg <= op_is_div(op_in) && (b == '0);
                        acc_hi_reg   <= '0;
                        if (op_is_div(op_in)) begin
                            acc_lo_reg  <= a_mag;   // dividend
                            operand_reg <= b_mag;   // divisor
                        end else begin
                            acc_lo_reg  <= b_mag;   // multiplier
                            operand_reg <= a_mag;   // multiplicand
                        end
                    end
                end
                CALC: begin
                    count_reg <= count_reg + 1'b1;
                    if (op_is_div(op_reg)) begin
                        if (div_fits) begin
                            acc_hi_reg <= div_diff[WIDTH-1:0];
                            acc_lo_reg <= {acc_lo_reg[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_hi_reg <= div_shift[WIDTH-1:0];
                            acc_lo_reg <= {acc_lo_reg[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_hi_reg <= mul_sum[WIDTH:1];
                        acc_lo_reg <= {mul_sum[0], acc_lo_reg[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    if (op_is_div(op_reg)) begin
                        hi_reg <= rem_fixed;
                        lo_reg <= quo_fixed;
                    end else begin
                        hi_reg <= prod_fixed[2*WIDTH-1:WIDTH];
                        lo_reg <= prod_fixed[WIDTH-1:0];
                    end
                    done_reg <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
// Table-driven directed vectors, hand-written multi-cycle sequences (ignored
// starts, reset abort, reset/start priority) and randomized operations
// checked against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_vec  = 0;
    int n_miss = 0;

    // Expected contents of HI/LO between operations.
    logic [31:0] model_hi = 32'h0;
    logic [31:0] model_lo = 32'h0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: returns {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] o,
                                               input logic [31:0] x,
                                               input logic [31:0] y);
        longint sx;
        longint sy;
        longint q;
        longint r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'b00: p = {32'h0, x} * {32'h0, y};
            2'b01: p = sx * sy;
            default: begin
                if (y == 32'h0) begin
                    p = {x, 32'hFFFFFFFF};
                end else if (o == 2'b10) begin
                    p = {x % y, x / y};
                end else begin
                    q = sx / sy;
                    r = sx % sy;
                    p = {r[31:0], q[31:0]};
                end
            end
        endcase
        return p;
    endfunction

    // One complete operation, started so that the start edge is the first
    // rising edge after the call. Returns once done has been observed.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input string tag);
        int lat;
        bit held;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        // Operand changes while busy must be ignored.
        start = 1'b0;
        op    = 2'($urandom);
        a     = $urandom;
        b     = $urandom;
        check({tag, "/busy"}, busy, 1);
        check({tag, "/done_single"}, done, 0);
        lat  = 0;
        held = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = c;
                break;
            end
            if (hi !== model_hi || lo !== model_lo) held = 1'b0;
        end
        check({tag, "/latency"}, lat, 33);
        check({tag, "/hold"}, held, 1);
        check({tag, "/hi"}, hi, exp_hi);
        check({tag, "/lo"}, lo, exp_lo);
        check({tag, "/idle"}, busy, 0);
        $display("%s op=%0d a=%h b=%h -> hi=%h lo=%h lat=%0d",
                 tag, o, x, y, hi, lo, lat);
        model_hi = exp_hi;
        model_lo = exp_lo;
    endtask

    initial begin
        logic [63:0] e;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int          dn;

        vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2]  = '{2'b10, 32'd100,      32'd7,        32'd2,        32'd14};
        vecs[3]  = '{2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4]  = '{2'b11, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
        vecs[5]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[6]  = '{2'b11, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        vecs[7]  = '{2'b11, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3};
        vecs[8]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[9]  = '{2'b01, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[10] = '{2'b10, 32'd0,        32'd0,        32'd0,        32'hFFFFFFFF};
        vecs[11] = '{2'b11, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[12] = '{2'b00, 32'h12345678, 32'd0,        32'd0,        32'd0};
        vecs[13] = '{2'b10, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF};

        // ---- reset state, and reset winning over a simultaneous start ----
        rst   = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = 32'h0;
        b     = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset/busy", busy, 0);
        check("reset/done", done, 0);
        check("reset/hi", hi, 0);
        check("reset/lo", lo, 0);
        @(negedge clk);
        start = 1'b1;
        op    = 2'b00;
        a     = 32'h5;
        b     = 32'h6;
        @(posedge clk);
        #1;
        check("rst_prio/busy", busy, 0);
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        $display("reset sequence done");

        // ---- directed table ----
        for (int i = 0; i < NVEC; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi,
                   vecs[i].exp_lo, $sformatf("vec%0d", i));
        end

        // ---- starts during busy (cycle 10 and the E33 edge) are ignored ----
        e = ref_result(2'b00, 32'h12345678, 32'h9ABCDEF0);
        @(negedge clk);
        start = 1'b1;
        op    = 2'b00;
        a     = 32'h12345678;
        b     = 32'h9ABCDEF0;
        @(posedge clk);
        #1;
        start = 1'b0;
        dn    = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = (c == 10) || (c == 33);
            op    = 2'b11;
            a     = $urandom;
            b     = $urandom | 32'h1;
            @(posedge clk);
            #1;
            if (done) dn++;
        end
        start = 1'b0;
        check("ignore/done_count", dn, 1);
        check("ignore/busy", busy, 0);
        check("ignore/hi", hi, e[63:32]);
        check("ignore/lo", lo, e[31:0]);
        $display("ignored-start op=0 a=12345678 b=9abcdef0 -> hi=%h lo=%h dones=%0d",
                 hi, lo, dn);
        model_hi = e[63:32];
        model_lo = e[31:0];

        // ---- reset at cycle 20 of a MULTU aborts without a done ----
        @(negedge clk);
        start = 1'b1;
        op    = 2'b00;
        a     = 32'hDEADBEEF;
        b     = 32'h00C0FFEE;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort/busy", busy, 0);
        check("abort/done", done, 0);
        check("abort/hi", hi, 0);
        check("abort/lo", lo, 0);
        @(negedge clk);
        rst = 1'b0;
        dn  = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done) dn++;
        end
        check("abort/no_done", dn, 0);
        $display("abort op=0 a=deadbeef b=00c0ffee -> hi=%h lo=%h dones=%0d", hi, lo, dn);
        model_hi = 32'h0;
        model_lo = 32'h0;
        e = ref_result(2'b00, 32'h0000FFFF, 32'h00010001);
        run_op(2'b00, 32'h0000FFFF, 32'h00010001, e[63:32], e[31:0], "after_abort");

        // ---- randomized operations against the reference model ----
        for (int i = 0; i < 80; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'h0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) ra = 32'h80000000;
            e = ref_result(ro, ra, rb);
            run_op(ro, ra, rb, e[63:32], e[31:0], $sformatf("rand%0d", i));
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request a new operation; sampled only when busy=0.
REQ-005 SHALL have port op  input  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 SHALL have port a  input  WIDTH  multiplicand or dividend (rs), captured with start.
REQ-007 SHALL have port b  input  WIDTH  multiplier or divisor (rt), captured with start.
REQ-008 SHALL have port busy  output  1  operation in progress; start ignored while high.
REQ-009 SHALL have port done  output  1  single-cycle pulse marking the update of HI/LO.
REQ-010 SHALL have port hi  output  WIDTH  HI register: product upper half or remainder.
REQ-011 SHALL have port lo  output  WIDTH  LO register: product lower half or quotient.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, FIX; IDLE->CALC on start&!busy, CALC->FIX after 32 iterations, FIX->IDLE unconditionally.
REQ-013 SHALL, on accepting start at edge E0, latch op, |a|, |b|, and the result signs; signed ops use two's-complement magnitudes.
REQ-014 SHALL perform exactly one shift-add (multiply) or restoring shift-subtract (divide) step per edge E1..E32.
REQ-015 SHALL write hi/lo at edge E33 and hold done=1 for exactly the cycle following E33; fixed latency 33 cycles.
REQ-016 SHALL drive busy=1 from after E0 until after E33; a start sampled at E33 is ignored, so the earliest back-to-back start is sampled at E34.
REQ-017 SHALL keep hi/lo unchanged from start acceptance until E33.
REQ-018 SHALL, for MULT, negate the 64-bit product when the operand signs differ.
REQ-019 SHALL, for DIV, give the quotient the sign a^b and the remainder the sign of a (truncation toward zero).
REQ-020 SHALL, when b=0 on DIVU/DIV, still take 33 cycles and produce lo=32'hFFFFFFFF, hi=a.
REQ-021 SHALL, for DIV with a=32'h80000000 and b=32'hFFFFFFFF, produce lo=32'h80000000, hi=0.
REQ-022 SHALL ignore start and op/a/b changes while busy=1.

Reset
REQ-023 SHALL, on rst=1 at a clock edge, force state IDLE, busy=0, done=0, hi=0, lo=0, and clear all internal registers.
REQ-024 SHALL, on rst during CALC or FIX, abort the operation with no done pulse and no HI/LO update other than clearing to 0.
REQ-025 SHALL give rst priority over a simultaneous start.

Structure
REQ-026 SHALL take the op encodings, FSM state encodings and the iteration count 32 from the shared package mdu_pkg.
REQ-027 SHALL remain a single module with no sub-module; the add/subtract datapath is inline.

Verification
REQ-028 SHALL cover this case: MULTU a=32'hFFFFFFFF, b=32'hFFFFFFFF -> after 33 cycles, hi=32'hFFFFFFFE, lo=32'h00000001, done pulses once.
REQ-029 SHALL cover this case: MULT a=-3, b=7 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFEB.
REQ-030 SHALL cover this case: DIVU a=100, b=7 -> lo=14, hi=2; then DIV a=-7, b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
REQ-031 SHALL cover this case: DIV a=5, b=0 -> lo=32'hFFFFFFFF, hi=5; then DIV a=32'h80000000, b=32'hFFFFFFFF -> lo=32'h80000000, hi=0.
REQ-032 SHALL cover this case: second start pulsed at cycles 10 and 33 of a busy operation -> both ignored, a single done, hi/lo reflect only the first operation.
REQ-033 SHALL cover this case: rst asserted at cycle 20 of a MULTU -> next cycle busy=0, hi=lo=0, no done pulse; a new start afterward completes normally.
